instmem_arbiter: RTL and testbench

INSTMEM_ARBITER -- requirements
Module: instmem_arbiter

---
 rtl/instmem_arbiter_if.sv | 41 ++++
 rtl/instmem_arbiter.sv | 103 ++++++++++
 tb/tb_instmem_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instmem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters
// (fetch and loader) and the single-read/single-write memory block.
interface instmem_arbiter_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 7
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [WIDTH-1:0]  f_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [WIDTH-1:0]  l_wdata;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [WIDTH-1:0]  l_rdata;

  logic              we0;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [WIDTH-1:0]  wr_din0;
  logic [WIDTH-1:0]  rd_dout0;

  // Arbiter view
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, rd_dout0,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    output we0, rd_addr0, wr_addr0, wr_din0
  );

  // Requester/memory environment view
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, rd_dout0,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    input  we0, rd_addr0, wr_addr0, wr_din0
  );
endinterface

// File: rtl/instmem_arbiter.sv
// Two-requester arbiter for the instruction memory: loader writes go straight
// to the write port, reads share the read port round-robin with 1-cycle latency.
// Optional exclusive loader locking is compiled in with INSTMEM_ARB_LOCK_EN.
module instmem_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input logic             clk,
  input logic             rst,
  instmem_arbiter_if.slave bus
);

  localparam int unsigned ADDR_SPAN = 2 ** ADDR_W;

  if (ADDR_SPAN != DEPTH) begin : g_bad_depth
    $error("instmem_arbiter: DEPTH must equal 2**ADDR_W");
  end

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_last_rd;
  logic              r_f_rvalid;
  logic              r_l_rvalid;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_wr;
  logic              w_hazard;
  logic              w_f_blk;
  logic              w_f_elig;
  logic              w_l_elig;
  logic              w_f_gnt;
  logic              w_l_rd_gnt;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_wr     = !rst && bus.l_req && bus.l_we;
  // A fetch must not read a word that is being written in the same cycle
  assign w_hazard = w_wr && (bus.l_addr == bus.f_addr);

`ifdef INSTMEM_ARB_LOCK_EN
  logic r_lock_q;
  // Once lock has been held a full cycle, stop new fetch reads so LOCKED can be entered
  assign w_f_blk = (r_state == LOCKED) || (bus.l_lock && r_lock_q);
`else
  assign w_f_blk = (r_state == LOCKED);
`endif

  assign w_f_elig   = !rst && bus.f_req && !w_hazard && !w_f_blk;
  assign w_l_elig   = !rst && bus.l_req && !bus.l_we;
  assign w_f_gnt    = w_f_elig && (!w_l_elig || r_last_rd);
  assign w_l_rd_gnt = w_l_elig && (!w_f_elig || !r_last_rd);
  assign w_rd_addr  = w_f_gnt    ? bus.f_addr :
                      w_l_rd_gnt ? bus.l_addr : r_rd_addr;

  assign bus.f_gnt    = w_f_gnt;
  assign bus.l_gnt    = w_wr || w_l_rd_gnt;
  assign bus.we0      = w_wr;
  assign bus.wr_addr0 = w_wr ? bus.l_addr : '0;
  assign bus.wr_din0  = w_wr ? bus.l_wdata : '0;
  assign bus.rd_addr0 = w_rd_addr;
  assign bus.f_rvalid = r_f_rvalid;
  assign bus.l_rvalid = r_l_rvalid;
  assign bus.f_rdata  = bus.rd_dout0;
  assign bus.l_rdata  = bus.rd_dout0;

  // Owner tracking, round-robin history, read-address hold and lock FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB;
      r_last_rd  <= 1'b1;
      r_f_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_rd_addr  <= '0;
`ifdef INSTMEM_ARB_LOCK_EN
      r_lock_q   <= 1'b0;
`endif
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_l_rvalid <= w_l_rd_gnt;
      r_rd_addr  <= w_rd_addr;
      if (w_f_gnt) begin
        r_last_rd <= 1'b0;
      end else if (w_l_rd_gnt) begin
        r_last_rd <= 1'b1;
      end
`ifdef INSTMEM_ARB_LOCK_EN
      r_lock_q <= bus.l_lock;
      case (r_state)
        ARB:     if (bus.l_lock && !w_f_gnt) r_state <= LOCKED;
        LOCKED:  if (!bus.l_lock) r_state <= ARB;
        default: r_state <= ARB;
      endcase
`else
      r_state <= ARB;
`endif
    end
  end

endmodule

// File: tb/tb_instmem_arbiter.sv
// Self-checking bench for instmem_arbiter: vector table with a read-data
// scoreboard, plus hand-written reset sequences.
module tb_instmem_arbiter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 128;

  typedef struct {
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [WIDTH-1:0]  l_wdata;
    logic              l_lock;
    logic              e_fg;
    logic              e_lg;
  } vec_t;

  typedef struct {
    logic             vld;
    logic             own;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  vec_t vecs[$];
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  instmem_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();

  instmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Memory block model: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus_if.we0) begin
      mem[bus_if.wr_addr0] <= bus_if.wr_din0;
    end
    bus_if.rd_dout0 <= mem[bus_if.rd_addr0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int fr, input int fa, input int lr, input int lw,
                              input int la, input logic [31:0] ld, input int lk,
                              input int fg, input int lg);
    vec_t v;
    v.f_req = 1'(fr); v.f_addr = 7'(fa);
    v.l_req = 1'(lr); v.l_we = 1'(lw); v.l_addr = 7'(la); v.l_wdata = ld;
    v.l_lock = 1'(lk); v.e_fg = 1'(fg); v.e_lg = 1'(lg);
    return v;
  endfunction

  task automatic check_rvalid(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_f_rvalid"}, 32'(bus_if.f_rvalid), 32'(e.vld && !e.own));
    chk({tag, "_l_rvalid"}, 32'(bus_if.l_rvalid), 32'(e.vld && e.own));
    if (e.vld && !e.own) chk({tag, "_f_rdata"}, bus_if.f_rdata, e.data);
    if (e.vld && e.own)  chk({tag, "_l_rdata"}, bus_if.l_rdata, e.data);
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    logic exp_we;
    @(negedge clk);
    check_rvalid(tag);
    bus_if.f_req   = v.f_req;
    bus_if.f_addr  = v.f_addr;
    bus_if.l_req   = v.l_req;
    bus_if.l_we    = v.l_we;
    bus_if.l_addr  = v.l_addr;
    bus_if.l_wdata = v.l_wdata;
    bus_if.l_lock  = v.l_lock;
    #1;
    exp_we = v.l_req && v.l_we;
    chk({tag, "_f_gnt"}, 32'(bus_if.f_gnt), 32'(v.e_fg));
    chk({tag, "_l_gnt"}, 32'(bus_if.l_gnt), 32'(v.e_lg));
    chk({tag, "_we0"},   32'(bus_if.we0),   32'(exp_we));
    if (exp_we) begin
      chk({tag, "_wr_addr0"}, 32'(bus_if.wr_addr0), 32'(v.l_addr));
      chk({tag, "_wr_din0"},  bus_if.wr_din0, v.l_wdata);
    end
    e.vld = 1'b0; e.own = 1'b0; e.data = '0;
    if (v.e_fg) begin
      e.vld = 1'b1; e.own = 1'b0; e.data = ref_mem[v.f_addr];
    end else if (v.e_lg && !v.l_we) begin
      e.vld = 1'b1; e.own = 1'b1; e.data = ref_mem[v.l_addr];
    end
    sb.push_back(e);
    if (exp_we) ref_mem[v.l_addr] = v.l_wdata;
  endtask

  function automatic exp_t no_rd();
    exp_t e;
    e.vld = 1'b0; e.own = 1'b0; e.data = '0;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'hA000_0000 + 32'(i);

    // Round-robin, write hazard, fetch streaming, loader streaming, parallel write+read
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 5, 1, 0, 9, 0, 0, (i % 2 == 0), (i % 2 == 1)));
    vecs.push_back(mk(1, 3, 1, 1, 3, 32'hDEAD_BEEF, 0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, i, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 10, 1, 0, 11, 0, 0, 0, 1));
    vecs.push_back(mk(1, 10, 1, 0, 11, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 20, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 21, 0, 0, 0, 1));
    vecs.push_back(mk(1, 6, 1, 1, 7, 32'h0000_1234, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 7, 0, 0, 0, 1));
`ifdef INSTMEM_ARB_LOCK_EN
    vecs.push_back(mk(1, 30, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 30, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 30, 1, 1, 64 + i, 32'(i), 1, 0, 1));
    vecs.push_back(mk(1, 30, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 30, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 66, 0, 0, 0, 1));
`endif
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset: requests held, everything must stay quiet
    bus_if.f_req = 1'b1; bus_if.f_addr = 7'd5;
    bus_if.l_req = 1'b1; bus_if.l_we = 1'b1; bus_if.l_addr = 7'd4;
    bus_if.l_wdata = 32'h5555_AAAA; bus_if.l_lock = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_f_gnt",    32'(bus_if.f_gnt),    32'd0);
    chk("rst_l_gnt",    32'(bus_if.l_gnt),    32'd0);
    chk("rst_we0",      32'(bus_if.we0),      32'd0);
    chk("rst_f_rvalid", 32'(bus_if.f_rvalid), 32'd0);
    chk("rst_l_rvalid", 32'(bus_if.l_rvalid), 32'd0);
    chk("rst_wr_addr0", 32'(bus_if.wr_addr0), 32'd0);
    chk("rst_wr_din0",  bus_if.wr_din0,       32'd0);
    chk("rst_rd_addr0", 32'(bus_if.rd_addr0), 32'd0);
    bus_if.f_req = 1'b0; bus_if.l_req = 1'b0; bus_if.l_we = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(no_rd());

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // Reset asserted mid-cycle while a fetch read is being granted
    step(mk(1, 2, 0, 0, 0, 0, 0, 1, 0), "pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_f_gnt",    32'(bus_if.f_gnt),    32'd0);
    chk("mid_rst_l_gnt",    32'(bus_if.l_gnt),    32'd0);
    chk("mid_rst_we0",      32'(bus_if.we0),      32'd0);
    chk("mid_rst_f_rvalid", 32'(bus_if.f_rvalid), 32'd0);
    chk("mid_rst_l_rvalid", 32'(bus_if.l_rvalid), 32'd0);
    sb.delete();
    sb.push_back(no_rd());
    @(negedge clk);
    bus_if.f_req = 1'b0;
    rst = 1'b0;
    // Fresh tie after reset goes to fetch again
    step(mk(1, 5, 1, 0, 9, 0, 0, 1, 0), "post_rst_tie");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle");
    @(negedge clk);
    check_rvalid("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
